// File: rtl/mcmem_bridge_pkg.sv
// Shared types and constants for the multicycle memory bridge.
// Holds the bridge FSM state enum, funct3 access-size codes and the
// access-size decode helper shared by the lane logic.
package mcmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } mcmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mcmem_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fetches are always words; unsigned codes only exist for loads, so a
  // store with BU/HU (or any unknown code) falls back to a word access.
  function automatic mcmem_size_t access_size(input logic       is_fetch,
                                              input logic       is_write,
                                              input logic [2:0] f3);
    mcmem_size_t sz;
    sz = SZ_W;
    if (!is_fetch) begin
      if (f3 == F3_B || (!is_write && f3 == F3_BU)) sz = SZ_B;
      else if (f3 == F3_H || (!is_write && f3 == F3_HU)) sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mcmem_lanes.sv
// Byte-lane logic for the memory bridge (purely combinational).
// Request side: byte enables, lane-replicated store data, misalignment.
// Response side: extraction and sign/zero extension of load data.
// Ports:
//   req_fetch/req_write/req_funct3/req_off/req_wdata : live request fields
//   be_c, wdata_c, misaligned_c                      : request lane results
//   ld_fetch/ld_funct3/ld_off                         : captured load fields
//   rsp_data, load_c                                  : raw word in, aligned load out
module mcmem_lanes
  import mcmem_bridge_pkg::*;
(
  input  logic        req_fetch,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic        misaligned_c,
  input  logic        ld_fetch,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rsp_data,
  output logic [31:0] load_c
);

  mcmem_size_t req_size;
  mcmem_size_t ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  // Request lanes: enables shifted to the offset, data replicated on all lanes.
  always_comb begin
    req_size     = access_size(req_fetch, req_write, req_funct3);
    be_c         = 4'b1111;
    wdata_c      = req_wdata;
    misaligned_c = 1'b0;
    case (req_size)
      SZ_B: begin
        be_c    = 4'b0001 << req_off;
        wdata_c = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be_c         = 4'b0011 << req_off;
        wdata_c      = {2{req_wdata[15:0]}};
        misaligned_c = req_off[0];
      end
      default: begin
        misaligned_c = (req_off != 2'b00);
      end
    endcase
  end

  // Load extraction; funct3[2] marks the unsigned variants.
  always_comb begin
    ld_size   = access_size(ld_fetch, 1'b0, ld_funct3);
    ld_byte   = rsp_data[{ld_off, 3'b000} +: 8];
    ld_half   = ld_off[1] ? rsp_data[31:16] : rsp_data[15:0];
    ld_signed = !ld_funct3[2];
    case (ld_size)
      SZ_B:    load_c = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    load_c = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: load_c = rsp_data;
    endcase
  end

endmodule

// File: rtl/mcmem_bridge.sv
// Variable-latency memory bridge between the multicycle control FSM and
// a valid/ready memory bus. One bus transaction per request level.
// Ports:
//   clk, reset                         : clock, async active-high reset
//   CTL_MemRead/CTL_MemWrite/CTL_IorD  : request levels from the control FSM
//   addr, wdata, funct3                : access address, store data, size/sign
//   mem_stall                          : hold the control FSM (combinational)
//   rdata, rdata_valid, misaligned     : load result and completion pulses
//   bus_req_*, bus_we/addr/wdata/be    : bus request channel
//   bus_rsp_valid, bus_rsp_data        : bus response channel
module mcmem_bridge
  import mcmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CTL_MemRead,
  input  logic              CTL_MemWrite,
  input  logic              CTL_IorD,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        funct3,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data
);

  mcmem_state_t state_q, state_d;
  logic         req_c;
  logic         capture_c;
  logic         ld_done_c;
  logic         mis_pulse_c;
  logic         lat_fetch_q;
  logic [2:0]   lat_funct3_q;
  logic [1:0]   lat_off_q;
  logic [3:0]   lane_be_c;
  logic [31:0]  lane_wdata_c;
  logic         lane_mis_c;
  logic [31:0]  lane_load_c;

  assign req_c     = CTL_MemRead | CTL_MemWrite;
  assign mem_stall = req_c && (state_q != DONE);

  mcmem_lanes u_lanes (
    .req_fetch    (!CTL_IorD),
    .req_write    (CTL_MemWrite),
    .req_funct3   (funct3),
    .req_off      (addr[1:0]),
    .req_wdata    (wdata),
    .be_c         (lane_be_c),
    .wdata_c      (lane_wdata_c),
    .misaligned_c (lane_mis_c),
    .ld_fetch     (lat_fetch_q),
    .ld_funct3    (lat_funct3_q),
    .ld_off       (lat_off_q),
    .rsp_data     (bus_rsp_data),
    .load_c       (lane_load_c)
  );

  // Next state and the single-cycle strobes feeding the output registers.
  always_comb begin
    state_d     = state_q;
    capture_c   = 1'b0;
    ld_done_c   = 1'b0;
    mis_pulse_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (lane_mis_c) begin
            state_d     = DONE;
            mis_pulse_c = 1'b1;
          end else begin
            state_d   = REQ;
            capture_c = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (bus_rsp_valid) begin
          state_d   = DONE;
          ld_done_c = !bus_we;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; bus fields only load when a bus cycle starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_req_valid <= 1'b0;
      rdata_valid   <= 1'b0;
      misaligned    <= 1'b0;
      rdata         <= '0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_be        <= '0;
      lat_fetch_q   <= 1'b0;
      lat_funct3_q  <= '0;
      lat_off_q     <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_valid <= (state_d == REQ);
      rdata_valid   <= ld_done_c;
      misaligned    <= mis_pulse_c;
      if (capture_c) begin
        bus_we       <= CTL_MemWrite;
        bus_addr     <= {addr[ADDR_W-1:2], 2'b00};
        bus_wdata    <= lane_wdata_c;
        bus_be       <= lane_be_c;
        lat_fetch_q  <= !CTL_IorD;
        lat_funct3_q <= funct3;
        lat_off_q    <= addr[1:0];
      end
      if (ld_done_c) rdata <= lane_load_c;
    end
  end

endmodule

// File: tb/tb_mcmem_bridge.sv
// Self-checking bench for mcmem_bridge: expected bus requests and load
// results are queued when an access is driven and compared when the
// bridge presents them.
module tb_mcmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        CTL_MemRead, CTL_MemWrite, CTL_IorD;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        rdata_valid, misaligned;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;

  always #5 clk = ~clk;

  mcmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .CTL_MemRead(CTL_MemRead), .CTL_MemWrite(CTL_MemWrite), .CTL_IorD(CTL_IorD),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .mem_stall(mem_stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misaligned(misaligned), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_data(bus_rsp_data)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_be;
  } req_exp_t;

  req_exp_t    req_q[$];
  logic [31:0] rd_q[$];
  int          mis_pending = 0;
  logic [31:0] model_rdata = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference models
  function automatic int m_bytes(input logic iord, input logic we, input logic [2:0] f3);
    if (!iord) return 4;
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b100:  return we ? 4 : 1;
      3'b101:  return we ? 4 : 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input int off, input int n);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] wd);
    if (n == 1) return {4{wd[7:0]}};
    if (n == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic iord, input logic [2:0] f3,
                                         input logic [1:0] off, input logic [31:0] w);
    logic [31:0] t;
    logic [7:0]  b;
    logic [15:0] h;
    t = w >> (8 * int'(off));
    b = t[7:0];
    h = off[1] ? w[31:16] : w[15:0];
    if (!iord) return w;
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Compare any completion pulse visible this cycle against the scoreboard.
  task automatic scan_pulses();
    logic [31:0] e;
    if (rdata_valid) begin
      if (rd_q.size() == 0) check("unexpected_rdata_valid", 32'(rdata_valid), 32'h0);
      else begin
        e = rd_q.pop_front();
        check("rdata", rdata, e);
        model_rdata = e;
      end
    end
    if (misaligned) begin
      if (mis_pending == 0) check("unexpected_misaligned", 32'(misaligned), 32'h0);
      else begin
        mis_pending--;
        check("rdata_hold_on_misaligned", rdata, model_rdata);
      end
    end
  endtask

  // Drive one access from a negedge and act as the bus slave until DONE.
  task automatic access(input string tag, input logic rd, input logic wr, input logic iord,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] rsp, input int rdy_dly, input int rsp_dly);
    req_exp_t    e, r;
    int          n, stalls, rdy_cnt, rsp_cnt, hs_count, exp_stall;
    logic        mis, hs, done, stable_ok, have_snap;
    logic [68:0] snap;
    n   = m_bytes(iord, wr, f3);
    mis = (int'(a[1:0]) % n) != 0;
    if (mis) mis_pending++;
    else begin
      e.we     = wr;
      e.addr   = {a[31:2], 2'b00};
      e.be     = m_be(int'(a[1:0]), n);
      e.wdata  = m_wdata(n, wd);
      e.chk_be = wr || !iord;
      req_q.push_back(e);
      if (!wr) rd_q.push_back(m_load(iord, f3, a[1:0], rsp));
    end
    exp_stall = mis ? 1 : 3 + rdy_dly + rsp_dly;
    CTL_MemRead = rd; CTL_MemWrite = wr; CTL_IorD = iord;
    addr = a; wdata = wd; funct3 = f3;
    stalls = 0; rdy_cnt = 0; rsp_cnt = 0; hs_count = 0;
    hs = 1'b0; done = 1'b0; stable_ok = 1'b1; have_snap = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      scan_pulses();
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'hDEADBEEF;
      if (bus_req_valid || hs) begin
        if (!have_snap) begin
          snap = {bus_we, bus_addr, bus_be, bus_wdata};
          have_snap = 1'b1;
        end else if (snap != {bus_we, bus_addr, bus_be, bus_wdata}) stable_ok = 1'b0;
      end
      if (bus_req_valid) begin
        if (rdy_cnt >= rdy_dly) begin
          bus_req_ready = 1'b1;
          hs = 1'b1;
          hs_count++;
          if (req_q.size() == 0) check({tag, "_spurious_req"}, 32'(bus_req_valid), 32'h0);
          else begin
            r = req_q.pop_front();
            check({tag, "_we"}, 32'(bus_we), 32'(r.we));
            check({tag, "_addr"}, bus_addr, r.addr);
            if (r.chk_be) check({tag, "_be"}, 32'(bus_be), 32'(r.be));
            if (r.we) check({tag, "_wdata"}, bus_wdata, r.wdata);
          end
        end else rdy_cnt++;
      end else if (hs) begin
        if (rsp_cnt >= rsp_dly) begin
          bus_rsp_valid = 1'b1;
          bus_rsp_data  = rsp;
        end else rsp_cnt++;
      end
      @(negedge clk);
    end
    if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, "_done_pulses"}, {30'h0, rdata_valid, misaligned}, {30'h0, !mis && !wr, mis});
    check({tag, "_transactions"}, 32'(hs_count), mis ? 32'h0 : 32'h1);
    if (!mis) check({tag, "_fields_stable"}, 32'(stable_ok), 32'h1);
    CTL_MemRead = 1'b0; CTL_MemWrite = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    scan_pulses();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    CTL_MemRead = 1'b0; CTL_MemWrite = 1'b0; CTL_IorD = 1'b0;
    addr = 32'h0; wdata = 32'h0; funct3 = 3'b000;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(bus_req_valid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {30'h0, rdata_valid, misaligned}, 32'h0);
    check("rst_bus", {bus_we, bus_addr[30:0]} | 32'(bus_be) | bus_wdata, 32'h0);
    check("rst_stall", 32'(mem_stall), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // tag, rd, wr, iord, addr, wdata, funct3, rsp_data, ready delay, rsp delay
    access("fetch",   1, 0, 0, 32'h100, 32'h0,        3'b000, 32'h00500093, 0, 0);
    access("lb",      1, 0, 1, 32'h203, 32'h0,        3'b000, 32'h80FF1234, 0, 0);
    access("lbu",     1, 0, 1, 32'h203, 32'h0,        3'b100, 32'h80FF1234, 0, 0);
    access("lh",      1, 0, 1, 32'h202, 32'h0,        3'b001, 32'h80FF1234, 0, 0);
    access("lhu",     1, 0, 1, 32'h202, 32'h0,        3'b101, 32'h80FF1234, 0, 0);
    access("lb_off1", 1, 0, 1, 32'h201, 32'h0,        3'b000, 32'h80FF1234, 0, 0);
    access("lw",      1, 0, 1, 32'h200, 32'h0,        3'b010, 32'h80FF1234, 0, 0);
    access("l_f3_011",1, 0, 1, 32'h204, 32'h0,        3'b011, 32'hCAFEF00D, 0, 0);
    access("sb",      0, 1, 1, 32'h101, 32'h000000AB, 3'b000, 32'h0,        0, 0);
    access("sh",      0, 1, 1, 32'h102, 32'h1234CDEF, 3'b001, 32'h0,        0, 0);
    access("sw",      0, 1, 1, 32'h104, 32'h89ABCDEF, 3'b010, 32'h0,        0, 0);
    access("s_f3_101",0, 1, 1, 32'h108, 32'h13579BDF, 3'b101, 32'h0,        0, 0);
    access("rw_both", 1, 1, 1, 32'h10C, 32'h000000C3, 3'b000, 32'h0,        0, 0);
    access("slow_lh", 1, 0, 1, 32'h302, 32'h0,        3'b001, 32'h7FFE0001, 4, 3);
    access("slow_sb", 0, 1, 1, 32'h303, 32'h00000055, 3'b000, 32'h0,        2, 1);
    access("mis_lw",  1, 0, 1, 32'h102, 32'h0,        3'b010, 32'h0,        0, 0);
    access("mis_sh",  0, 1, 1, 32'h103, 32'h0000FFFF, 3'b001, 32'h0,        0, 0);
    access("mis_lhu", 1, 0, 1, 32'h201, 32'h0,        3'b101, 32'h0,        0, 0);
    access("mis_fetch",1,0, 0, 32'h102, 32'h0,        3'b000, 32'h0,        0, 0);
    access("after_mis",1, 0, 1, 32'h203, 32'h0,       3'b000, 32'h00000071, 0, 0);

    // Reset while waiting for a read response; the late response must be dropped.
    CTL_MemRead = 1'b1; CTL_IorD = 1'b1; addr = 32'h200; funct3 = 3'b010;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    check("rst_mid_waiting", {30'h0, bus_req_valid, mem_stall}, 32'h1);
    CTL_MemRead = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_req_valid", 32'(bus_req_valid), 32'h0);
    check("rst_mid_bus_addr", bus_addr, 32'h0);
    check("rst_mid_bus_misc", {bus_we, 27'h0, bus_be} | bus_wdata, 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_flags", {30'h0, rdata_valid, misaligned}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h12345678;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("late_rsp_rdata_valid", 32'(rdata_valid), 32'h0);
      check("late_rsp_rdata", rdata, 32'h0);
      @(negedge clk);
    end

    check("req_queue_drained", 32'(req_q.size()), 32'h0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    check("mis_drained", 32'(mis_pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcmem_bridge.md
# mcmem_bridge

Variable-latency memory bridge for the multicycle core. Sits between the multicycle control FSM/datapath and the external memory bus. Turns the control unit's `CTL_MemRead`/`CTL_MemWrite` levels into a single valid/ready bus transaction, with byte-lane alignment, byte enables and load sign/zero extension. Raises `mem_stall` so the control FSM holds its current state until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, bus data width (only 32 supported)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `CTL_MemRead`  in  1  read request level from control FSM
- `CTL_MemWrite`  in  1  write request level from control FSM
- `CTL_IorD`  in  1  0 = instruction fetch (forced word access), 1 = data access
- `addr`  in  ADDR_W  byte address (PC or ALUOut, muxed in datapath)
- `wdata`  in  32  store data (rs2, unshifted)
- `funct3`  in  3  access size/sign from the instruction
- `mem_stall`  out  1  hold control FSM state
- `rdata`  out  32  aligned, extended load/fetch data (registered)
- `rdata_valid`  out  1  one-cycle pulse when `rdata` updates
- `misaligned`  out  1  one-cycle pulse: access aborted, no bus cycle
- `bus_req_valid`  out  1  bus request valid
- `bus_req_ready`  in  1  bus accepts request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  ADDR_W  word-aligned address (`[1:0]` = 0)
- `bus_wdata`  out  32  lane-replicated store data
- `bus_be`  out  4  byte enables
- `bus_rsp_valid`  in  1  response/ack (reads and writes)
- `bus_rsp_data`  in  32  raw read word

## Operation
States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: if `CTL_MemRead|CTL_MemWrite`, latch `addr`, `wdata`, `funct3`, `CTL_IorD` and op. Write has priority if both are set.
  - Misaligned (half with `addr[0]`, word with `addr[1:0]!=0`): go to DONE with the error flag set.
  - Otherwise go to REQ.
- REQ: `bus_req_valid=1` with stable fields until `bus_req_ready`. Then go to WAIT_RSP.
- WAIT_RSP: on `bus_rsp_valid`, go to DONE. For reads, register the extended data into `rdata`.
- DONE: pulse `rdata_valid` (read, no error) or `misaligned` (error). Always go to IDLE.
- `mem_stall = (CTL_MemRead|CTL_MemWrite) && state != DONE`. It is therefore high in IDLE on a new request.
- `bus_rsp_valid` is ignored outside WAIT_RSP.
- Fetch (`CTL_IorD=0`): word access, `bus_be=4'b1111`, `funct3` ignored.
- Loads: offset `o=addr[1:0]`.
  - LB 000: sign-extend byte `o`.
  - LH 001: sign-extend half `o[1]`.
  - LW 010: full word.
  - LBU 100, LHU 101: zero-extend.
  - Other codes: treated as LW.
- Stores:
  - SB 000: `be=4'b0001<<o`, byte replicated ×4.
  - SH 001: `be=4'b0011<<o`, half replicated ×2.
  - SW 010: `be=4'b1111`.
  - Other codes: treated as SW.

## Timing
- Reset (async): state IDLE; `bus_req_valid=0`, `rdata=0`, `rdata_valid=0`, `misaligned=0`, `bus_we=0`, `bus_addr=0`, `bus_be=0`, `bus_wdata=0`.
- Reset mid-transaction abandons the access. A late response is dropped because the FSM is back in IDLE.
- Bus outputs are registered and change only on leaving IDLE. They are held through REQ and WAIT_RSP.
- Minimum latency with ready and rsp asserted immediately: request seen cycle 0 (IDLE) → REQ cycle 1 → WAIT_RSP cycle 2 → DONE cycle 3.
  - `mem_stall` is high cycles 0–2 and low cycle 3.
  - `rdata` is valid from cycle 3 and held until the next read completes.
- Misaligned access: IDLE cycle 0 → DONE cycle 1; stall high 1 cycle; no `bus_req_valid`.
- Back-to-back requests: DONE→IDLE always costs one cycle before the next request is sampled.

## Structure
- Shared package: `mcmem_state_t` enum, funct3 load/store constants (`F3_B/H/W/BU/HU`).
- Sub-module `mcmem_lanes` (combinational): store lane replication + `bus_be`, load extraction/extension, misalignment detect.
- Top level: FSM and capture registers.

## Test plan
- Fetch at `addr=0x100`, ready and rsp immediate, `bus_rsp_data=0x00500093` → `bus_be=1111`, `bus_addr=0x100`, stall for 3 cycles, `rdata=0x00500093`, `rdata_valid` in cycle 3.
- LB at `0x203`, rsp data `0x80FF1234` → `bus_addr=0x200`, `rdata=0xFFFFFF80`. LBU at the same address → `0x00000080`. LH at `0x202` → `0xFFFF80FF`.
- SB at `0x101`, `wdata=0x000000AB` → `bus_be=0010`, `bus_wdata=0xABABABAB`, `bus_we=1`. SH at `0x102` → `be=1100`.
- `bus_req_ready` low for 4 cycles, then rsp 3 cycles later → request fields stable throughout, stall high until DONE, exactly one transaction.
- LW at `0x102` → `misaligned` pulse in cycle 1, no `bus_req_valid`, `rdata` unchanged.
- Assert `reset` during WAIT_RSP, then pulse `bus_rsp_valid` → all outputs go to reset values immediately, response ignored, `rdata_valid` stays 0.
